// File: rtl/byte_mem_responder.sv
// Byte-serial memory responder: internal byte RAM plus memory-mapped TX/RX byte FIFOs and a halt flag.
// Loads return their byte one cycle later; stores and idle cycles leave the load result unchanged.

module byte_mem_responder_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count
);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
endmodule

module byte_mem_responder #(
    parameter int unsigned RAM_AW  = 17,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_valid_from_fc,
    input  logic        is_store_from_fc,
    input  logic [31:0] addr_from_fc,
    input  logic [7:0]  data_from_fc,
    output logic [7:0]  data_to_fc,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow,
    output logic        is_halt
);
    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
    localparam int unsigned CW        = FIFO_AW + 1;

    logic [7:0]    ram [RAM_DEPTH];

    logic          is_io;
    logic          is_data;
    logic          is_ctrl;
    logic          is_load;
    logic          is_store;
    logic          ram_we;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_drop;
    logic          tx_empty;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_empty;
    logic          rx_full;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic [3:0]    rx_count_sat;
    logic [7:0]    load_data_c;
    logic          unused_bits;

    assign unused_bits = ^{addr_from_fc[31:18], tx_count};

    // Request decode: addr[17:16]==2'b11 selects I/O, offset 0 is DATA and 4 is CTRL.
    assign is_io    = (addr_from_fc[17:16] == 2'b11);
    assign is_data  = is_io && (addr_from_fc[2:0] == 3'd0);
    assign is_ctrl  = is_io && (addr_from_fc[2:0] == 3'd4);
    assign is_load  = is_valid_from_fc && !is_store_from_fc;
    assign is_store = is_valid_from_fc && is_store_from_fc;
    assign ram_we   = rst && is_store && !is_io;

    // A push into a full TX FIFO survives only when the host drains a byte in the same cycle.
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = is_store && is_data;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop     = tx_push_req && tx_full && !tx_pop;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = is_load && is_data && !rx_empty;

    byte_mem_responder_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (data_from_fc),
        .rdata (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_mem_responder_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_from_fc[RAM_AW-1:0]] <= data_from_fc;
    end

    assign rx_count_sat = (32'(rx_count) > 32'd15) ? 4'hF : 4'(rx_count);

    // Read mux for the byte returned on the following cycle.
    always_comb begin
        load_data_c = 8'h00;
        if (!is_io) begin
            load_data_c = ram[addr_from_fc[RAM_AW-1:0]];
        end else if (is_data) begin
            load_data_c = rx_empty ? 8'h00 : rx_head;
        end else if (is_ctrl) begin
            load_data_c = {is_halt, tx_overflow, tx_valid, !rx_empty, rx_count_sat};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_to_fc  <= 8'h00;
            tx_overflow <= 1'b0;
            is_halt     <= 1'b0;
        end else begin
            if (is_load)              data_to_fc  <= load_data_c;
            if (tx_drop)              tx_overflow <= 1'b1;
            if (is_store && is_ctrl)  is_halt     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed bench for byte_mem_responder: RAM round trip, TX/RX FIFO boundaries, CTRL status, halt and async reset.

module tb_byte_mem_responder;
    logic        clk;
    logic        rst;
    logic        is_valid_from_fc;
    logic        is_store_from_fc;
    logic [31:0] addr_from_fc;
    logic [7:0]  data_from_fc;
    logic [7:0]  data_to_fc;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        tx_overflow;
    logic        is_halt;

    int n_checks;
    int n_fails;

    byte_mem_responder dut (
        .clk              (clk),
        .rst              (rst),
        .is_valid_from_fc (is_valid_from_fc),
        .is_store_from_fc (is_store_from_fc),
        .addr_from_fc     (addr_from_fc),
        .data_from_fc     (data_from_fc),
        .data_to_fc       (data_to_fc),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_overflow      (tx_overflow),
        .is_halt          (is_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic st, input logic [31:0] a, input logic [7:0] d);
        is_valid_from_fc = 1'b1;
        is_store_from_fc = st;
        addr_from_fc     = a;
        data_from_fc     = d;
    endtask

    task automatic idle();
        is_valid_from_fc = 1'b0;
        is_store_from_fc = 1'b0;
        addr_from_fc     = 32'h0;
        data_from_fc     = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // Reset held with random request traffic
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            is_valid_from_fc = 1'($urandom);
            is_store_from_fc = 1'($urandom);
            addr_from_fc     = $urandom;
            data_from_fc     = 8'($urandom);
            tx_ready         = 1'($urandom);
            rx_valid         = 1'($urandom);
            rx_data          = 8'($urandom);
            step();
        end
        check("rst_data_to_fc", 32'(data_to_fc), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_is_halt", 32'(is_halt), 32'h0);
        check("rst_tx_overflow", 32'(tx_overflow), 32'h0);
        idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step();
        rst = 1'b1;
        step();

        // RAM store then load, result held across idle cycles
        req(1'b1, 32'h0000_0123, 8'hA5);
        step();
        req(1'b0, 32'h0000_0123, 8'h00);
        step();
        check("ram_load", 32'(data_to_fc), 32'hA5);
        idle();
        step(); step(); step();
        check("ram_hold", 32'(data_to_fc), 32'hA5);

        // TX fill past full with no host drain
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            req(1'b1, 32'h0003_0000, 8'(i));
            step();
            if (i == 15) check("tx_no_ovf_at_16", 32'(tx_overflow), 32'h0);
        end
        check("tx_ovf_after_17", 32'(tx_overflow), 32'h1);
        check("tx_valid_full", 32'(tx_valid), 32'h1);
        idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_drain_%0d", i), 32'(tx_data), 32'(i));
            step();
        end
        check("tx_empty_after_drain", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Async reset clears the sticky overflow
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        check("ovf_cleared", 32'(tx_overflow), 32'h0);
        step();

        // Push into full TX while host pops the same cycle
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 32'h0003_0000, 8'(8'h80 + i));
            step();
        end
        req(1'b1, 32'h0003_0000, 8'h5A);
        tx_ready = 1'b1;
        step();
        check("tx_full_push_pop_no_ovf", 32'(tx_overflow), 32'h0);
        idle();
        for (int i = 1; i < 16; i++) begin
            check($sformatf("tx_pp_drain_%0d", i), 32'(tx_data), 32'(8'h80 + i));
            step();
        end
        check("tx_pp_last_5a", 32'(tx_data), 32'h5A);
        step();
        check("tx_pp_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // RX: two host bytes, status, then three DATA reads
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        step();
        rx_data  = 8'h22;
        step();
        rx_valid = 1'b0;
        req(1'b0, 32'h0003_0004, 8'h00);
        step();
        check("ctrl_rx2", 32'(data_to_fc), 32'h12);
        req(1'b0, 32'h0003_0000, 8'h00);
        step();
        check("rx_read_11", 32'(data_to_fc), 32'h11);
        step();
        check("rx_read_22", 32'(data_to_fc), 32'h22);
        step();
        check("rx_read_empty", 32'(data_to_fc), 32'h00);
        req(1'b0, 32'h0003_0001, 8'h00);
        step();
        check("io_unmapped_read", 32'(data_to_fc), 32'h00);
        idle();

        // RX fill to full; the 17th offered byte must be refused
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h40 + i);
            step();
        end
        check("rx_full_not_ready", 32'(rx_ready), 32'h0);
        rx_data = 8'hEE;
        step();
        rx_valid = 1'b0;
        req(1'b0, 32'h0003_0004, 8'h00);
        step();
        check("ctrl_rx_sat", 32'(data_to_fc), 32'h1F);
        req(1'b0, 32'h0003_0000, 8'h00);
        step();
        check("rx_full_head", 32'(data_to_fc), 32'h40);
        check("rx_ready_after_pop", 32'(rx_ready), 32'h1);

        // Halt flag, then TX traffic still served while halted
        req(1'b1, 32'h0003_0004, 8'h00);
        step();
        check("halt_set", 32'(is_halt), 32'h1);
        req(1'b0, 32'h0003_0004, 8'h00);
        step();
        check("ctrl_halted", 32'(data_to_fc), 32'h9F);
        for (int i = 1; i < 4; i++) begin
            req(1'b1, 32'h0003_0000, 8'(i));
            step();
        end
        check("tx_while_halted", 32'(tx_valid), 32'h1);
        check("store_keeps_load_data", 32'(data_to_fc), 32'h9F);
        idle();

        // Async reset mid-burst, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'h0);
        check("async_is_halt", 32'(is_halt), 32'h0);
        check("async_data_to_fc", 32'(data_to_fc), 32'h00);
        check("async_rx_ready", 32'(rx_ready), 32'h1);
        step();
        rst = 1'b1;
        step();
        req(1'b0, 32'h0000_0123, 8'h00);
        step();
        check("ram_survives_reset", 32'(data_to_fc), 32'hA5);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
